tape_bridge: RTL
================

// Module: tape_bridge
// PURPOSE
// - Upstream client of the SDRAM controller's tape port (bank 2); sole driver of tape_addr/tape_din/tape_wr/tape_rd.
// - Write path: buffers IO-controller download bytes in a FIFO and writes them to SDRAM.
// - Read path: fetches single bytes on request for the tape player.
// - Converts level requests to the controller's toggle-ack handshake. Keeps at most one access outstanding.
// PARAMETERS
// - FIFO_DEPTH  4   write FIFO entries; power of two, >=2
// - SETTLE      16  clocks with tape_rd/tape_wr low after reset before ack resync; >=2 SDRAM cycles (8 clk each)
// PORTS
// - clk         in   1   SDRAM clock, same as SDRAM controller
// - reset       in   1   synchronous, active-high
// - ioctl_wr    in   1   1-clk strobe: write ioctl_dout to ioctl_addr
// - ioctl_addr  in   23  byte address of download byte
// - ioctl_dout  in   8   download byte
// - ioctl_wait  out  1   FIFO full; strobes taken while high are dropped
// - play_req    in   1   1-clk strobe: read byte at play_addr
// - play_addr   in   23  byte address for read
// - play_busy   out  1   read accepted and not yet returned
// - play_dout   out  8   returned byte; held until next return
// - play_valid  out  1   1-clk pulse: play_dout updated
// - tape_addr   out  23  to controller
// - tape_din    out  8   to controller, write data
// - tape_wr     out  1   to controller, write request level
// - tape_rd     out  1   to controller, read request level
// - tape_dout   in   8   from controller, read data
// - tape_ack    in   1   from controller; toggles once per completed tape access
// BEHAVIOUR
// - One clock, clk. Reset is synchronous and active-high.
// - Reset values: ioctl_wait=0, play_busy=0, play_dout=8'h00, play_valid=0, tape_wr=0, tape_rd=0, tape_addr=0, tape_din=0.
// - Reset also empties the FIFO and drops any pending read.
// - Write FIFO holds {addr[22:0],data[7:0]} and uses wrap-around pointers.
// - FIFO has an occupancy count of 0..FIFO_DEPTH; ioctl_wait = (count==FIFO_DEPTH), registered.
// - Push and pop in the same clock leave count unchanged. A push at full is ignored and the data is lost.
// - Read latch: play_req with play_busy=0 captures play_addr; play_busy goes 1 next clk.
// - play_req with play_busy=1 is ignored.
// - FSM states:
//   - SETTLE: tape_wr=tape_rd=0; counter runs SETTLE clocks; then ack_seen<=tape_ack and go IDLE.
//   - IDLE: if the FIFO is non-empty (priority), drive the FIFO head onto tape_addr/tape_din and set tape_wr=1, go WR.
//     Else if a read is pending, drive its address onto tape_addr and set tape_rd=1, go RD.
//   - WR: when tape_ack!=ack_seen, set tape_wr=0, pop the FIFO, ack_seen<=tape_ack, go IDLE.
//   - RD: when tape_ack!=ack_seen, set tape_rd=0, play_dout<=tape_dout, play_valid=1 for 1 clk, play_busy=0, ack_seen<=tape_ack, go IDLE.
// - Reset in any state enters SETTLE, so an in-flight ack cannot be mistaken for a new one.
// - tape_wr and tape_rd are never both 1. tape_addr and tape_din are stable whenever either is high.
// - The request level must drop the clock after the ack toggle is seen; the controller re-samples the level every 8 clk.
// - Minimum turnaround: a new request may start on the clock after returning to IDLE.
// - Latency, read: play_req to play_valid is at most 3 clk + 2 SDRAM cycles when the FIFO is empty.
// - Read starvation: a sustained ioctl stream delays reads; allowed, since downloads and playback are exclusive.
// TESTING
// - Reset then ack model idle:
//   - -> tape_wr/tape_rd stay 0 for SETTLE clk.
//   - Then push 0x000010/0xA5 -> tape_wr=1, tape_addr=0x000010, tape_din=0xA5 until ack toggles.
//   - Then tape_wr=0 and the FIFO is empty.
// - Burst of 6 ioctl_wr on consecutive clk, FIFO_DEPTH=4, slow ack:
//   - -> ioctl_wait=1 after the 4th; bytes 5-6 are dropped.
//   - Exactly 4 writes reach the model in order.
// - play_req addr 0x000123 with model byte 0x3C:
//   - -> tape_rd=1 with tape_addr=0x000123.
//   - After ack: play_dout=0x3C, play_valid 1 clk, play_busy=0.
// - Read pending while the FIFO is non-empty -> all FIFO writes issue first, then the read. tape_wr and tape_rd are never both high.
// - Second play_req while play_busy=1 -> ignored; exactly one tape_rd access is issued.
// - Reset asserted while tape_rd=1, with the ack toggling 5 clk later:
//   - -> no play_valid.
//   - After SETTLE, a new write completes normally using the resynced ack.

Source files
------------

// File: rtl/tape_bridge.sv
// tape_bridge: client of the SDRAM controller's tape port.
// Download bytes from the IO controller are queued in a small write FIFO and
// written to SDRAM one at a time. Single-byte reads are fetched for the tape
// player. Level requests (tape_wr/tape_rd) are converted to the controller's
// toggle-ack handshake, with at most one access outstanding.
module tape_bridge #(
    parameter int FIFO_DEPTH = 4,   // write FIFO entries, power of two, >= 2
    parameter int SETTLE     = 16   // quiet clocks after reset before ack resync
) (
    input  logic        clk,
    input  logic        reset,
    // IO controller download side
    input  logic        ioctl_wr,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    // tape player read side
    input  logic        play_req,
    input  logic [22:0] play_addr,
    output logic        play_busy,
    output logic [7:0]  play_dout,
    output logic        play_valid,
    // SDRAM controller tape port
    output logic [22:0] tape_addr,
    output logic [7:0]  tape_din,
    output logic        tape_wr,
    output logic        tape_rd,
    input  logic [7:0]  tape_dout,
    input  logic        tape_ack
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE - 1);

    // FSM encoding
    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_WR     = 2'd2;
    localparam logic [1:0] ST_RD     = 2'd3;

    // Each FIFO entry is {addr[22:0], data[7:0]}
    logic [30:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    logic [1:0]        state_reg;
    logic [SET_W-1:0]  settle_reg;
    logic              ack_seen_reg;
    logic              ack_hit;
    logic [22:0]       pend_addr_reg;

    // Handshake and FIFO control decode
    always_comb begin
        ack_hit    = tape_ack ^ ack_seen_reg;
        fifo_empty = (count_reg == '0);
        // A strobe at full is dropped even if a pop happens in the same clock
        push       = ioctl_wr && (count_reg != COUNT_FULL);
        pop        = (state_reg == ST_WR) && ack_hit;
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointers, occupancy and the registered full flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg  <= count_next;
            // Computed from the next count so it always mirrors count==FIFO_DEPTH
            ioctl_wait <= (count_next == COUNT_FULL);
        end
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {ioctl_addr, ioctl_dout};
        end
    end

    // Access sequencer: settle after reset, issue writes before reads,
    // and retire each access on the ack toggle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_SETTLE;
            settle_reg    <= '0;
            ack_seen_reg  <= 1'b0;
            tape_wr       <= 1'b0;
            tape_rd       <= 1'b0;
            tape_addr     <= '0;
            tape_din      <= '0;
            play_busy     <= 1'b0;
            play_dout     <= 8'h00;
            play_valid    <= 1'b0;
            pend_addr_reg <= '0;
        end else begin
            play_valid <= 1'b0;

            // Read latch: only one read can be pending at a time
            if (play_req && !play_busy) begin
                pend_addr_reg <= play_addr;
                play_busy     <= 1'b1;
            end

            case (state_reg)
                ST_SETTLE: begin
                    // Let any access that was in flight at reset finish,
                    // then adopt the current ack level as the baseline
                    tape_wr <= 1'b0;
                    tape_rd <= 1'b0;
                    if (settle_reg == SETTLE_END) begin
                        ack_seen_reg <= tape_ack;
                        state_reg    <= ST_IDLE;
                    end else begin
                        settle_reg <= settle_reg + SET_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {tape_addr, tape_din} <= fifo_mem[rd_ptr_reg];
                        tape_wr   <= 1'b1;
                        state_reg <= ST_WR;
                    end else if (play_busy) begin
                        tape_addr <= pend_addr_reg;
                        tape_rd   <= 1'b1;
                        state_reg <= ST_RD;
                    end
                end
                ST_WR: begin
                    if (ack_hit) begin
                        tape_wr      <= 1'b0;
                        ack_seen_reg <= tape_ack;
                        state_reg    <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (ack_hit) begin
                        tape_rd      <= 1'b0;
                        play_dout    <= tape_dout;
                        play_valid   <= 1'b1;
                        play_busy    <= 1'b0;
                        ack_seen_reg <= tape_ack;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_SETTLE;
                end
            endcase
        end
    end

endmodule
